// File: rtl/dis_compositor.sv
// dis_compositor: aligns display timing with the sprite-layer latency, picks
// the highest-priority opaque layer (or background), applies a frame-aligned
// white hit flash, and registers RGB565 display outputs.
module dis_compositor #(
   parameter int          LAYERS       = 4,
   parameter int          LATENCY      = 4,
   parameter logic [15:0] BG_COLOR     = 16'h4E19,
   parameter int          FLASH_FRAMES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_de,
   input  logic                 in_hsync,
   input  logic                 in_vsync,
   input  logic [LAYERS-1:0]    layer_enable,
   input  logic [16*LAYERS-1:0] layer_color,
   input  logic                 flash_trigger,
   output logic                 out_de,
   output logic                 out_hsync,
   output logic                 out_vsync,
   output logic [4:0]           out_r,
   output logic [5:0]           out_g,
   output logic [4:0]           out_b,
   output logic                 flash_active
);

   localparam int             CW       = $clog2(FLASH_FRAMES + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(FLASH_FRAMES);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_FLASH = 2'd2;

   logic [LATENCY-1:0] de_dl, hs_dl, vs_dl;
   logic               a_de, a_hs, a_vs;
   logic               prev_vs;
   logic               boundary;
   logic [1:0]         state, state_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [15:0]        sel_color;
   logic [15:0]        color;

   // Timing delay line; the tail lines up with the layer paint outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_dl <= '0;
         hs_dl <= '0;
         vs_dl <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            de_dl[i] <= de_dl[i-1];
            hs_dl[i] <= hs_dl[i-1];
            vs_dl[i] <= vs_dl[i-1];
         end
         de_dl[0] <= in_de;
         hs_dl[0] <= in_hsync;
         vs_dl[0] <= in_vsync;
      end
   end

   assign a_de     = de_dl[LATENCY-1];
   assign a_hs     = hs_dl[LATENCY-1];
   assign a_vs     = vs_dl[LATENCY-1];
   assign boundary = a_vs & ~prev_vs;

   // Priority select: walk from lowest priority up so layer 0 wins last.
   always_comb begin
      sel_color = BG_COLOR;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (layer_enable[i]) sel_color = layer_color[16*i +: 16];
      end
   end

   // Flash FSM next state; a trigger while flashing reloads even on a boundary.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (flash_trigger) state_nx = S_ARMED;
         end
         S_ARMED: begin
            if (boundary) begin
               state_nx = S_FLASH;
               cnt_nx   = CNT_LOAD;
            end
         end
         S_FLASH: begin
            if (flash_trigger) begin
               cnt_nx = CNT_LOAD;
            end else if (boundary) begin
               if (cnt == CNT_ONE) begin
                  state_nx = S_IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt - CNT_ONE;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Pixel colour uses the same flash value that flash_active will take,
   // so the flash and the pixel stream switch on the same edge.
   always_comb begin
      color = sel_color;
      if (state_nx == S_FLASH) color = 16'hFFFF;
      if (!a_de) color = 16'h0000;
   end

   // FSM, boundary history and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         prev_vs      <= 1'b0;
         flash_active <= 1'b0;
         out_de       <= 1'b0;
         out_hsync    <= 1'b0;
         out_vsync    <= 1'b0;
         out_r        <= '0;
         out_g        <= '0;
         out_b        <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         prev_vs      <= a_vs;
         flash_active <= (state_nx == S_FLASH);
         out_de       <= a_de;
         out_hsync    <= a_hs;
         out_vsync    <= a_vs;
         out_r        <= color[15:11];
         out_g        <= color[10:5];
         out_b        <= color[4:0];
      end
   end

endmodule
